// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types for the RV32M multiply issue controller: funct3 encodings,
// FSM state encoding and default widths.
package mul_issue_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int TIMEOUT_DEF = 63;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Request / multiplier / writeback bundle for mul_issue_ctrl.
// slave = the controller, master = the environment (pipeline plus multiplier).
interface mul_issue_ctrl_if #(
  parameter int XLEN = mul_issue_pkg::XLEN_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_rs1;
  logic [XLEN-1:0]   req_rs2;
  logic              mul_start;
  logic [XLEN-1:0]   mul_rs1;
  logic [XLEN-1:0]   mul_rs2;
  logic              mul_signed;
  logic [2*XLEN-1:0] mul_result;
  logic              mul_valid;
  logic              mul_busy;
  logic              rd_valid;
  logic [XLEN-1:0]   rd_data;
  logic              rd_err;
  logic              stall;

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, mul_result, mul_valid, mul_busy,
    output req_ready, mul_start, mul_rs1, mul_rs2, mul_signed, rd_valid, rd_data, rd_err, stall
  );

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, mul_result, mul_valid, mul_busy,
    input  req_ready, mul_start, mul_rs1, mul_rs2, mul_signed, rd_valid, rd_data, rd_err, stall
  );

endinterface

// File: rtl/mul_issue_ctrl_result_sel.sv
// Combinational writeback select: picks the product half for the op and applies
// the MULHSU correction to an unsigned product.
module mul_result_sel
  import mul_issue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2*XLEN-1:0] i_prod,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  output logic [XLEN-1:0]   o_data
);

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_MUL:            o_data = i_prod[XLEN-1:0];
      F3_MULH, F3_MULHU: o_data = i_prod[2*XLEN-1:XLEN];
      // Unsigned high half minus rs2 when rs1 was negative gives the signed x unsigned result.
      F3_MULHSU:         o_data = i_prod[2*XLEN-1:XLEN] - (i_rs1[XLEN-1] ? i_rs2 : '0);
      default:           o_data = '0;
    endcase
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller between execute and the iterative multiplier.
// Optional feature macro: MUL_ZERO_BYPASS_EN (zero operand skips the multiplier).
module mul_issue_ctrl
  import mul_issue_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  mul_issue_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic [2:0]        r_funct3;
  logic              r_signed;
  logic              r_err;
  logic [2*XLEN-1:0] r_prod;
  logic [CW-1:0]     r_cnt;

  logic              w_start;
  logic              w_skip;
  logic              w_timeout;
  logic              w_zero;
  logic [XLEN-1:0]   w_sel;

`ifdef MUL_ZERO_BYPASS_EN
  assign w_zero = (r_rs1 == '0) || (r_rs2 == '0);
`else
  assign w_zero = 1'b0;
`endif

  // Decode is resolved in LAUNCH so illegal and bypassed ops both answer two cycles after accept.
  assign w_skip    = r_funct3[2] || w_zero;
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      IDLE:    if (bus.req_valid) w_state_next = LAUNCH;
      LAUNCH: begin
        if (w_skip) begin
          w_state_next = DONE;
        end else begin
          w_start      = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT:    if (bus.mul_valid || w_timeout) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_funct3 <= '0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_rs1    <= bus.req_rs1;
            r_rs2    <= bus.req_rs2;
            r_funct3 <= bus.req_funct3;
            r_signed <= (bus.req_funct3 == F3_MULH);
            r_err    <= 1'b0;
            r_prod   <= '0;
          end
        end
        LAUNCH: begin
          r_cnt <= '0;
          if (r_funct3[2]) r_err <= 1'b1;
        end
        WAIT: begin
          if (bus.mul_valid) begin
            r_prod <= bus.mul_result;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  mul_result_sel #(.XLEN(XLEN)) u_sel (
    .i_prod   (r_prod),
    .i_funct3 (r_funct3),
    .i_rs1    (r_rs1),
    .i_rs2    (r_rs2),
    .o_data   (w_sel)
  );

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.stall      = (r_state != IDLE);
  assign bus.mul_start  = w_start;
  assign bus.mul_rs1    = r_rs1;
  assign bus.mul_rs2    = r_rs2;
  assign bus.mul_signed = r_signed;
  assign bus.rd_valid   = (r_state == DONE);
  assign bus.rd_err     = (r_state == DONE) && r_err;
  assign bus.rd_data    = ((r_state == DONE) && !r_err) ? w_sel : '0;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed and random multiply requests against an
// arithmetic reference model, with an in-bench multiplier stub.
module tb_mul_issue_ctrl;
  import mul_issue_pkg::*;

  localparam int XLEN = 32;
  localparam int TO   = 63;
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl_if #(.XLEN(XLEN)) bus ();

  mul_issue_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width products from the RV32M definitions.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f3)
      3'b000:  begin p = ua * ub; return p[31:0];  end
      3'b001:  begin p = sa * sb; return p[63:32]; end
      3'b010:  begin p = sa * ub; return p[63:32]; end
      3'b011:  begin p = ua * ub; return p[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] stub_prod(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    if (s) return sa * sb;
    return longint'({32'b0, a}) * longint'({32'b0, b});
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit respond);
    logic [31:0] exp_data;
    bit          exp_err;
    bit          early;
    int          exp_cyc;
    int          starts    = 0;
    int          start_cyc = -1;
    int          rd_cyc    = -1;

    early    = f3[2] || (BYPASS && (a == 0 || b == 0));
    exp_err  = f3[2] || !respond;
    exp_data = exp_err ? 32'h0 : ref_mul(f3, a, b);
    if (early)         exp_cyc = 2;
    else if (!respond) exp_cyc = 2 + TO + 1;
    else               exp_cyc = 2 + lat;

    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_rs1    = a;
    bus.req_rs2    = b;

    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      chk("stall_busy", bus.stall, 1);
      chk("req_ready_busy", bus.req_ready, 0);
      chk("hold_rs1", bus.mul_rs1, a);
      chk("hold_rs2", bus.mul_rs2, b);
      chk("hold_signed", bus.mul_signed, f3 == F3_MULH);
      // Ignored garbage request while busy.
      bus.req_funct3 = 3'($urandom);
      bus.req_rs1    = $urandom;
      bus.req_rs2    = $urandom;
      if (bus.mul_start) begin
        starts++;
        start_cyc    = cyc;
        bus.mul_busy = 1'b1;
      end
      if (bus.mul_valid) begin
        bus.mul_valid = 1'b0;
        bus.mul_busy  = 1'b0;
      end
      if (bus.rd_valid) begin
        rd_cyc = cyc;
        chk("rd_data", bus.rd_data, exp_data);
        chk("rd_err", bus.rd_err, exp_err);
        bus.req_valid = 1'b0;
        break;
      end
      if (early && cyc == 1) begin
        bus.mul_valid  = 1'b1;
        bus.mul_result = {$urandom, $urandom};
      end
      if (respond && start_cyc > 0 && cyc == start_cyc + lat) begin
        bus.mul_valid  = 1'b1;
        bus.mul_result = stub_prod(bus.mul_signed, bus.mul_rs1, bus.mul_rs2);
      end
    end
    bus.req_valid = 1'b0;
    bus.mul_valid = 1'b0;
    bus.mul_busy  = 1'b0;
    chk("rd_latency", 64'(rd_cyc), 64'(exp_cyc));
    chk("start_count", 64'(starts), early ? 64'd0 : 64'd1);
    @(negedge clk);
    chk("rd_pulse_once", bus.rd_valid, 0);
    chk("idle_after", bus.stall, 0);
    $display("op f3=%b rs1=%h rs2=%h lat=%0d resp=%0d -> exp data=%h err=%0d at cycle %0d",
             f3, a, b, lat, respond, exp_data, exp_err, exp_cyc);
  endtask

  initial begin
    int rd_seen;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.mul_result = '0;
    bus.mul_valid  = 1'b0;
    bus.mul_busy   = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_stall", bus.stall, 0);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_err", bus.rd_err, 0);
    chk("rst_mul_rs1", bus.mul_rs1, 0);
    chk("rst_mul_signed", bus.mul_signed, 0);
    rst = 1'b0;

    run_op(3'b000, 32'd7,        32'd6,        3, 1'b1);
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b1);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 1'b1);
    run_op(3'b010, 32'hFFFFFFFF, 32'h00000002, 1, 1'b1);
    run_op(3'b001, 32'h80000000, 32'h80000000, 5, 1'b1);
    run_op(3'b101, 32'h12345678, 32'h9ABCDEF0, 1, 1'b1);
    run_op(3'b111, 32'h1,        32'h1,        1, 1'b1);
    run_op(3'b000, 32'h0,        32'h00001234, 2, 1'b1);
    run_op(3'b010, 32'hFFFFFFFF, 32'h0,        2, 1'b1);
    run_op(3'b011, 32'hDEADBEEF, 32'h12345678, 1, 1'b0);

    // Reset while waiting on a silent multiplier.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_rs1    = 32'd3;
    bus.req_rs2    = 32'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_stall", bus.stall, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_ready", bus.req_ready, 1);
    chk("rst_wait_stall", bus.stall, 0);
    chk("rst_wait_rd_valid", bus.rd_valid, 0);
    rst = 1'b0;
    rd_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_valid) rd_seen++;
    end
    chk("rst_no_rd", 64'(rd_seen), 0);
    $display("reset in WAIT -> idle, rd pulses=%0d", rd_seen);

    for (int i = 0; i < 40; i++) begin
      rf3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       ra = 32'h0;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'h7FFFFFFF;
        2:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      run_op(rf3, ra, rb, $urandom_range(1, 6), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
